// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: FSM state encoding and default frame parameters
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop rx synchroniser and sample_clk rising-edge tick detector
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic sample_clk,
    output logic rx_s,
    output logic tick
);

    logic rx_meta_q, rx_meta_d;
    logic rx_s_q, rx_s_d;
    logic sclk_q, sclk_d;

    // next-state for the synchroniser chain and the sample_clk history flop
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        sclk_d    = sample_clk;
    end

    // synchroniser resets to idle-high so reset release never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            sclk_q    <= sclk_d;
        end
    end

    assign rx_s = rx_s_q;
    assign tick = sample_clk & ~sclk_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with one-entry valid/ready holding register (option UART_RX_PARITY_EN)
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int            TW       = $clog2(OVERSAMPLE + 1);
    localparam logic [TW-1:0] CNT_HALF = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] CNT_FULL = TW'(OVERSAMPLE);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0]    ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0]    ST_AFTER_DATA = ST_STOP;
`endif

    logic                 rx_s, tick;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d, tick_nxt;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 perr_d;
    logic                 par_bad;

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .sample_clk (sample_clk),
        .rx_s       (rx_s),
        .tick       (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d, perr_q;
    assign par_bad = (par_q != ^shift_q);

    // received parity bit and the registered parity error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end
    assign parity_err = perr_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // frame FSM, bit sampling and completion/handshake decisions; everything advances on tick only
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q & ~rx_ready;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        perr_d     = 1'b0;
        tick_nxt   = tick_cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
`endif
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d    = ST_START;
                        tick_cnt_d = TW'(1);
                    end
                end
                ST_START: begin
                    tick_cnt_d = tick_nxt;
                    if (tick_nxt == CNT_HALF) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    tick_cnt_d = tick_nxt;
                    if (tick_nxt == CNT_FULL) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bit_cnt_q == 3'(i)) shift_d[i] = rx_s;
                        end
                        if (bit_cnt_q == BIT_LAST) state_d = ST_AFTER_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    tick_cnt_d = tick_nxt;
                    if (tick_nxt == CNT_FULL) begin
                        tick_cnt_d = '0;
                        par_d      = rx_s;
                        state_d    = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    tick_cnt_d = tick_nxt;
                    if (tick_nxt == CNT_FULL) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = ST_IDLE;
                        if (!rx_s) begin
                            ferr_d = 1'b1;
                        end else if (par_bad) begin
                            perr_d = 1'b1;
                        end else if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end
    end

    // state, counters, shift/holding registers and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed table-driven bench for uart_rx
module tb_uart_rx;

    localparam int OS        = 16;
    localparam int DB        = 8;
    localparam int TICK_CLKS = 4;
    localparam int BIT_CLKS  = OS * TICK_CLKS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_clk = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_err, overrun, parity_err;

    int n_chk = 0;
    int n_err = 0;

    int valid_cyc = 0;
    int acc_cnt   = 0;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    int perr_cnt  = 0;
    logic [DB-1:0] last_data = '0;

    int s_valid, s_acc, s_ferr, s_ovr, s_perr;

    typedef struct {
        logic [DB-1:0] data;
        logic          stop;
        int            exp_acc;
        logic [DB-1:0] exp_last;
        int            exp_ferr;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_clk (sample_clk),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial begin
        forever begin
            @(negedge clk);
            sample_clk = 1'b1;
            @(negedge clk);
            sample_clk = 1'b0;
            repeat (TICK_CLKS - 2) @(negedge clk);
        end
    end

    always @(negedge clk) begin
        if (rx_valid) valid_cyc <= valid_cyc + 1;
        if (rx_valid && rx_ready) begin
            acc_cnt   <= acc_cnt + 1;
            last_data <= rx_data;
        end
        if (frame_err)  ferr_cnt <= ferr_cnt + 1;
        if (overrun)    ovr_cnt  <= ovr_cnt + 1;
        if (parity_err) perr_cnt <= perr_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < DB; i++) drive_bit(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        drive_bit(par, BIT_CLKS);
`else
        if (par === 1'bx) $display("unexpected parity argument");
`endif
        if (stop) begin
            drive_bit(1'b1, BIT_CLKS);
        end else begin
            drive_bit(1'b0, 10 * TICK_CLKS);
            drive_bit(1'b1, BIT_CLKS - 10 * TICK_CLKS);
        end
    endtask

    task automatic snap();
        s_valid = valid_cyc;
        s_acc   = acc_cnt;
        s_ferr  = ferr_cnt;
        s_ovr   = ovr_cnt;
        s_perr  = perr_cnt;
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_acc: 1, exp_last: 8'hA5, exp_ferr: 0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_acc: 0, exp_last: 8'hA5, exp_ferr: 1};
        vecs[2] = '{data: 8'h00, stop: 1'b1, exp_acc: 1, exp_last: 8'h00, exp_ferr: 0};
        vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_acc: 1, exp_last: 8'hFF, exp_ferr: 0};
        vecs[4] = '{data: 8'h81, stop: 1'b0, exp_acc: 0, exp_last: 8'hFF, exp_ferr: 1};
        vecs[5] = '{data: 8'h5A, stop: 1'b1, exp_acc: 1, exp_last: 8'h5A, exp_ferr: 0};

        repeat (5) @(negedge clk);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        check("reset parity_err", 32'(parity_err), 32'd0);
        rst_n = 1'b1;
        drive_bit(1'b1, 2 * BIT_CLKS);

        // short low glitch must not produce a frame
        snap();
        drive_bit(1'b0, 4 * TICK_CLKS);
        drive_bit(1'b1, 2 * BIT_CLKS);
        check("glitch valid", 32'(valid_cyc - s_valid), 32'd0);
        check("glitch frame_err", 32'(ferr_cnt - s_ferr), 32'd0);

        rx_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            snap();
            send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop);
            drive_bit(1'b1, BIT_CLKS);
            check($sformatf("vec%0d accepted", v), 32'(acc_cnt - s_acc), 32'(vecs[v].exp_acc));
            check($sformatf("vec%0d valid cycles", v), 32'(valid_cyc - s_valid), 32'(vecs[v].exp_acc));
            check($sformatf("vec%0d data", v), 32'(last_data), 32'(vecs[v].exp_last));
            check($sformatf("vec%0d frame_err", v), 32'(ferr_cnt - s_ferr), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d overrun", v), 32'(ovr_cnt - s_ovr), 32'd0);
        end

        // back-to-back frames with consumer stalled: second frame overruns
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, ^8'h11, 1'b1);
        send_frame(8'h22, ^8'h22, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        check("b2b rx_valid", 32'(rx_valid), 32'd1);
        check("b2b rx_data held", 32'(rx_data), 32'h11);
        check("b2b overrun", 32'(ovr_cnt - s_ovr), 32'd1);
        check("b2b frame_err", 32'(ferr_cnt - s_ferr), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("b2b drained", 32'(rx_valid), 32'd0);

        // reset in the middle of data bit 3 with a byte held
        send_frame(8'h99, ^8'h99, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        check("pre-reset held", 32'(rx_valid), 32'd1);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS / 2);
        rst_n = 1'b0;
        #1;
        check("midreset rx_valid", 32'(rx_valid), 32'd0);
        check("midreset rx_data", 32'(rx_data), 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b1, BIT_CLKS);
        rx_ready = 1'b1;
        snap();
        send_frame(8'h5A, ^8'h5A, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        check("post-reset accepted", 32'(acc_cnt - s_acc), 32'd1);
        check("post-reset data", 32'(last_data), 32'h5A);
        check("post-reset frame_err", 32'(ferr_cnt - s_ferr), 32'd0);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b0, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        check("bad parity err", 32'(perr_cnt - s_perr), 32'd1);
        check("bad parity accepted", 32'(acc_cnt - s_acc), 32'd0);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        check("good parity err", 32'(perr_cnt - s_perr), 32'd0);
        check("good parity accepted", 32'(acc_cnt - s_acc), 32'd1);
        check("good parity data", 32'(last_data), 32'h07);
`else
        check("parity_err never", 32'(perr_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive stage directly downstream of the sample-clock generator (`sample`).
- Consumes `sample_clk` as an oversampling strobe (OVERSAMPLE ticks per bit) and deserialises the asynchronous `rx` line into bytes.
- Presents each byte through a one-entry valid/ready holding register to the SoC bus/FIFO, with frame, overrun and optional parity error flags.

Parameters:
- OVERSAMPLE, 16: sample_clk ticks per bit period; even, ≥4.
- DATA_BITS, 8: payload bits per frame, LSB first; range 5..8.

Ports:
- clk  input  1  system clock; same clock that drives `sample`.
- rst_n  input  1  asynchronous active-low reset.
- sample_clk  input  1  oversample clock from `sample`, synchronous to clk; a tick = one clk cycle in which a sample_clk rising edge is detected.
- rx  input  1  serial line, asynchronous, idle high.
- rx_data  output  DATA_BITS  received byte, valid while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts; transfer occurs when rx_valid & rx_ready at a clk edge.
- frame_err  output  1  1-cycle pulse: stop bit sampled 0.
- overrun  output  1  1-cycle pulse: frame completed while holding register still full.
- parity_err  output  1  1-cycle pulse: parity mismatch; constant 0 without UART_RX_PARITY_EN.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, FSM=IDLE, counters=0. The synchroniser resets to 1 so no false start is seen.
- `rx` passes through a 2-flop synchroniser; the FSM uses the synchronised value. sample_clk is edge-detected with one register to form `tick`. All FSM and counter activity advances only on tick.
- FSM states IDLE, START, DATA, PARITY (macro only), STOP:
  - IDLE: on a tick with rx_s=0, go to START and set tick_cnt=1.
  - START: on the tick where tick_cnt reaches OVERSAMPLE/2 (mid start bit), check rx_s. If 0, go to DATA with tick_cnt=0 and bit_cnt=0. If 1, treat as a glitch and return to IDLE with no flag.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift[bit_cnt] (LSB first). After DATA_BITS samples, go to PARITY if enabled, otherwise STOP.
  - STOP: after OVERSAMPLE ticks (mid stop bit), sample rx_s and return to IDLE on the same tick, so back-to-back frames are supported.
- Completion, evaluated at the mid-stop tick; outputs update on the following clk edge:
  - stop=0: frame_err pulses; byte discarded; rx_valid unchanged.
  - stop=1 and parity bad: parity_err pulses; byte discarded.
  - stop=1, good parity, rx_valid=0 (or rx_valid & rx_ready in the same cycle): rx_data=shift, rx_valid=1.
  - stop=1, good parity, rx_valid=1 & !rx_ready: overrun pulses; new byte dropped; rx_data keeps the old byte.
- Handshake: rx_valid clears on the edge where rx_valid & rx_ready. rx_data is stable while rx_valid=1. rx_ready while rx_valid=0 is ignored.
- Latency: rx_valid rises 1 clk after the mid-stop tick, plus 2 clk of synchroniser delay on the rx edges.
- Counters: tick_cnt is ceil(log2(OVERSAMPLE+1)) bits wide. bit_cnt is 3 bits wide and must not wrap before DATA_BITS.
- rst_n low mid-frame: immediate return to reset values; the partial byte is lost. After release, the first falling rx edge starts a new frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - One bit is sampled at mid-bit; the expected value is even parity (XOR of data bits).
  - Mismatch produces a parity_err pulse and the byte is discarded.
- Undefined:
  - No PARITY state.
  - parity_err tied to 0.
  - Frame is start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg:
  - FSM state encoding constants.
  - Default OVERSAMPLE/DATA_BITS localparams.
  - Shared with the future uart_tx.
- One sub-module, uart_rx_sync:
  - 2-flop rx synchroniser plus sample_clk rising-edge detector.
  - Outputs rx_s and tick.
  - Reusable by uart_tx for tick generation.

Test Plan:
- Send 0xA5 (8N1, 16 ticks/bit), rx_ready=1 -> rx_valid=1 for exactly 1 cycle with rx_data=0xA5; no error pulses.
- rx low for 4 ticks then high -> FSM returns to IDLE; no rx_valid, no flags.
- Send 0x3C with stop bit forced 0 -> one frame_err pulse; rx_valid stays 0.
- Send 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_valid=1 with rx_data=0x11, one overrun pulse at end of the second frame; after rx_ready=1, rx_valid=0.
- Assert rst_n=0 during data bit 3 of 0xFF -> all outputs 0 within the same cycle; a subsequent 0x5A is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (expected 1) -> parity_err pulse, no rx_valid; resend with parity 1 -> rx_data=0x07, rx_valid=1.
